// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter and the pixel fetcher.
package vga_fb_arbiter_pkg;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StTurn,
    StWrSetup,
    StWrPulse
  } arb_state_e;

  // Cycles from a read being issued on the SRAM pins to disp_data_valid.
  localparam int unsigned ReadLatency = 2;

endpackage

// File: rtl/vga_fb_req_latch.sv
// One-deep holding register for display requests that arrive while a write
// owns the bus, plus a sticky flag for requests that had to be dropped.
module vga_fb_req_latch #(
  parameter int unsigned AddrBits = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [AddrBits-1:0] req_addr_i,
  input  logic                bypass_i,  // request is issued directly, do not hold it
  input  logic                pop_i,     // held request is issued this cycle
  input  logic                refill_i,  // a pop frees the slot for a same-cycle request
  output logic                pend_valid_o,
  output logic [AddrBits-1:0] pend_addr_o,
  output logic                overrun_o
);

  logic                valid_q;
  logic [AddrBits-1:0] addr_q;
  logic                overrun_q;
  logic                store;
  logic                drop;

  // Decide whether an incoming request is held or dropped.
  always_comb begin
    store = 1'b0;
    drop  = 1'b0;
    if (req_i && !bypass_i) begin
      if (!valid_q || (pop_i && refill_i)) begin
        store = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Slot state; the older request always wins over a dropped one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (store) begin
        valid_q <= 1'b1;
        addr_q  <= req_addr_i;
      end else if (pop_i) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign pend_valid_o = valid_q;
  assign pend_addr_o  = addr_q;
  assign overrun_o    = overrun_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port async SRAM arbiter: display reads have strict priority, the
// writer takes every remaining slot. All pin-facing outputs are registered.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 20,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_req,
  input  logic [ADDR_BITS-1:0] disp_addr,
  output logic [DATA_BITS-1:0] disp_data,
  output logic                 disp_data_valid,
  output logic                 disp_overrun,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_data_out,
  output logic                 sram_data_oe,
  input  logic [DATA_BITS-1:0] sram_data_in,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  arb_state_e state_q, state_d;

  logic                 pend_valid;
  logic [ADDR_BITS-1:0] pend_addr;
  logic                 in_rd_slot;  // IDLE or READ
  logic                 issue_slot;  // any state whose successor may be READ
  logic                 issue;
  logic [ADDR_BITS-1:0] issue_addr;
  logic                 wr_accept;

  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic                 data_oe_q, ce_n_q, oe_n_q, we_n_q;
  logic                 rd_pend_q;
  logic [DATA_BITS-1:0] rd_cap_q;
  logic [DATA_BITS-1:0] disp_data_q;
  logic                 disp_valid_q;

  assign in_rd_slot = (state_q == StIdle) || (state_q == StRead);
  assign issue_slot = in_rd_slot || (state_q == StWrPulse);
  assign issue      = issue_slot && (disp_req || pend_valid);
  // A held request is older than a fresh one, so it goes first.
  assign issue_addr = pend_valid ? pend_addr : disp_addr;
  // WR_PULSE is included so a waiting writer can chain writes without idling.
  assign wr_ready   = issue_slot && !disp_req && !pend_valid;
  assign wr_accept  = wr_valid && wr_ready;

  vga_fb_req_latch #(
    .AddrBits(ADDR_BITS)
  ) u_req_latch (
    .clk_i        (clk),
    .rst_ni       (reset),
    .req_i        (disp_req),
    .req_addr_i   (disp_addr),
    .bypass_i     (issue_slot && !pend_valid),
    .pop_i        (issue_slot && pend_valid),
    .refill_i     (in_rd_slot),
    .pend_valid_o (pend_valid),
    .pend_addr_o  (pend_addr),
    .overrun_o    (disp_overrun)
  );

  // Next-state selection; display reads always beat the writer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRead: begin
        if (issue) begin
          state_d = StRead;
        end else if (wr_accept) begin
          // Coming out of a read the SRAM may still be driving: turn the bus.
          state_d = (state_q == StRead) ? StTurn : StWrSetup;
        end else begin
          state_d = StIdle;
        end
      end
      StTurn:    state_d = StWrSetup;
      StWrSetup: state_d = StWrPulse;
      StWrPulse: begin
        if (issue) begin
          state_d = StRead;
        end else if (wr_accept) begin
          state_d = StWrSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  // State, registered strobes and the address/data held across a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_oe_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ce_n_q    <= !((state_d == StRead) || (state_d == StWrSetup) || (state_d == StWrPulse));
      oe_n_q    <= (state_d != StRead);
      we_n_q    <= (state_d != StWrPulse);
      data_oe_q <= (state_d == StWrSetup) || (state_d == StWrPulse);
      if (issue) begin
        addr_q <= issue_addr;
      end else if (wr_accept) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end
    end
  end

  // Read return pipe: capture the SRAM bus, then present it one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q    <= 1'b0;
      rd_cap_q     <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_pend_q <= (state_q == StRead);
      if (state_q == StRead) begin
        rd_cap_q <= sram_data_in;
      end
      disp_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        disp_data_q <= rd_cap_q;
      end
    end
  end

  assign sram_addr       = addr_q;
  assign sram_data_out   = wdata_q;
  assign sram_data_oe    = data_oe_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign disp_data       = disp_data_q;
  assign disp_data_valid = disp_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed stimulus, read/write scoreboards and an
// SRAM behavioural model.
module tb_vga_fb_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_data_valid;
  logic          disp_overrun;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_out;
  logic          sram_data_oe;
  logic [DW-1:0] sram_data_in = '0;
  logic          sram_ce_n, sram_oe_n, sram_we_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]      rd_q[$];
  logic [AW+DW-1:0]   wr_q[$];
  logic [DW-1:0]      mem[logic [AW-1:0]];
  logic               prev_we_n = 1'b1;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_BITS(AW),
    .DATA_BITS(DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .disp_req        (disp_req),
    .disp_addr       (disp_addr),
    .disp_data       (disp_data),
    .disp_data_valid (disp_data_valid),
    .disp_overrun    (disp_overrun),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .sram_addr       (sram_addr),
    .sram_data_out   (sram_data_out),
    .sram_data_oe    (sram_data_oe),
    .sram_data_in    (sram_data_in),
    .sram_ce_n       (sram_ce_n),
    .sram_oe_n       (sram_oe_n),
    .sram_we_n       (sram_we_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM contents: written words, one fixed word at 0x123, a pattern elsewhere.
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == 20'h00123) return 16'hBEEF;
    return a[DW-1:0] ^ 16'hA5A5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor + SRAM model, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (disp_data_valid) begin
        chk("rd_q_nonempty", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) chk("rd_data", 32'(disp_data), 32'(rd_q.pop_front()));
      end
      if (!sram_we_n) begin
        chk("we_single_cycle", 32'(prev_we_n), 32'd1);
        chk("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          logic [AW+DW-1:0] e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(sram_addr), 32'(e[AW+DW-1:DW]));
          chk("wr_data", 32'(sram_data_out), 32'(e[DW-1:0]));
        end
        if (!sram_ce_n) mem[sram_addr] = sram_data_out;
      end
      if (sram_data_oe || !sram_oe_n) chk("bus_contention", 32'(sram_data_oe && !sram_oe_n), 32'd0);
      prev_we_n = sram_we_n;
    end else begin
      prev_we_n = 1'b1;
    end
    sram_data_in = (!sram_oe_n && !sram_ce_n) ? mem_rd(sram_addr) : '0;
  end

  initial begin
    logic [DW-1:0] b2b_exp [4];
    b2b_exp[0] = 16'hA5A5;
    b2b_exp[1] = 16'hA5A4;
    b2b_exp[2] = 16'hA5A7;
    b2b_exp[3] = 16'hA5A6;

    // Reset values.
    #12;
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_data_out", 32'(sram_data_out), 32'd0);
    chk("rst_disp_valid", 32'(disp_data_valid), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    chk("rst_overrun", 32'(disp_overrun), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    step();
    reset = 1'b1;
    step();

    // Read latency.
    disp_req = 1'b1;
    disp_addr = 20'h00123;
    rd_q.push_back(16'hBEEF);
    step();
    disp_req = 1'b0;
    chk("lat_addr", 32'(sram_addr), 32'h123);
    chk("lat_oe_n", 32'(sram_oe_n), 32'd0);
    chk("lat_ce_n", 32'(sram_ce_n), 32'd0);
    chk("lat_valid_n0", 32'(disp_data_valid), 32'd0);
    step();
    chk("lat_valid_n1", 32'(disp_data_valid), 32'd0);
    step();
    chk("lat_valid_n2", 32'(disp_data_valid), 32'd1);
    chk("lat_data_n2", 32'(disp_data), 32'hBEEF);
    step();
    chk("lat_valid_n3", 32'(disp_data_valid), 32'd0);

    // Four back-to-back reads with the writer waiting.
    wr_valid = 1'b1;
    wr_addr = 20'h00040;
    wr_data = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      disp_req = 1'b1;
      disp_addr = AW'(i);
      rd_q.push_back(b2b_exp[i]);
      step();
      chk("b2b_oe_n", 32'(sram_oe_n), 32'd0);
      chk("b2b_addr", 32'(sram_addr), 32'(i));
      chk("b2b_wr_ready", 32'(wr_ready), 32'd0);
    end
    disp_req = 1'b0;
    wr_valid = 1'b0;
    step();
    step();
    step();

    // Read then write: one turnaround cycle.
    disp_req = 1'b1;
    disp_addr = 20'h00010;
    rd_q.push_back(16'hA5B5);
    step();
    disp_req = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 20'h00020;
    wr_data = 16'h5A5A;
    wr_q.push_back({20'h00020, 16'h5A5A});
    #1;
    chk("rw_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    chk("turn_oe_n", 32'(sram_oe_n), 32'd1);
    chk("turn_data_oe", 32'(sram_data_oe), 32'd0);
    chk("turn_we_n", 32'(sram_we_n), 32'd1);
    step();
    chk("setup_data_oe", 32'(sram_data_oe), 32'd1);
    chk("setup_we_n", 32'(sram_we_n), 32'd1);
    chk("setup_ce_n", 32'(sram_ce_n), 32'd0);
    chk("setup_addr", 32'(sram_addr), 32'h20);
    chk("setup_data", 32'(sram_data_out), 32'h5A5A);
    step();
    chk("pulse_we_n", 32'(sram_we_n), 32'd0);
    chk("pulse_addr", 32'(sram_addr), 32'h20);
    chk("pulse_data", 32'(sram_data_out), 32'h5A5A);
    step();
    chk("post_we_n", 32'(sram_we_n), 32'd1);
    chk("post_data_oe", 32'(sram_data_oe), 32'd0);
    step();

    // Display request during WR_SETUP is held and issued after WR_PULSE.
    wr_valid = 1'b1;
    wr_addr = 20'h00030;
    wr_data = 16'hC3C3;
    wr_q.push_back({20'h00030, 16'hC3C3});
    step();
    wr_valid = 1'b0;
    chk("idle_wr_setup_oe", 32'(sram_data_oe), 32'd1);
    chk("idle_wr_setup_we", 32'(sram_we_n), 32'd1);
    disp_req = 1'b1;
    disp_addr = 20'h00020;
    rd_q.push_back(16'h5A5A);
    step();
    disp_req = 1'b0;
    chk("held_pulse_we_n", 32'(sram_we_n), 32'd0);
    chk("held_pulse_addr", 32'(sram_addr), 32'h30);
    chk("held_pulse_data", 32'(sram_data_out), 32'hC3C3);
    step();
    chk("held_rd_oe_n", 32'(sram_oe_n), 32'd0);
    chk("held_rd_addr", 32'(sram_addr), 32'h20);
    chk("held_overrun", 32'(disp_overrun), 32'd0);
    step();

    // Two requests during one write: the second is dropped.
    wr_valid = 1'b1;
    wr_addr = 20'h00050;
    wr_data = 16'h0F0F;
    wr_q.push_back({20'h00050, 16'h0F0F});
    step();
    wr_valid = 1'b0;
    disp_req = 1'b1;
    disp_addr = 20'h00123;
    rd_q.push_back(16'hBEEF);
    step();
    disp_addr = 20'h00003;
    step();
    disp_req = 1'b0;
    chk("ovr_rd_addr", 32'(sram_addr), 32'h123);
    chk("ovr_rd_oe_n", 32'(sram_oe_n), 32'd0);
    chk("ovr_flag", 32'(disp_overrun), 32'd1);
    step();
    chk("ovr_no_2nd_oe_n", 32'(sram_oe_n), 32'd1);
    chk("ovr_no_2nd_addr", 32'(sram_addr), 32'h123);
    chk("ovr_sticky", 32'(disp_overrun), 32'd1);

    // Reset in the middle of WR_PULSE.
    wr_valid = 1'b1;
    wr_addr = 20'h00077;
    wr_data = 16'h1234;
    step();
    wr_valid = 1'b0;
    step();
    chk("mid_pulse_we_n", 32'(sram_we_n), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("mid_rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("mid_rst_overrun", 32'(disp_overrun), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("post_rst_oe_n", 32'(sram_oe_n), 32'd1);
    step();
    step();

    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
